// File: rtl/calib_burst_seq_if.sv
// Request/config bus between the calibration configuration side and calib_burst_seq.
interface calib_burst_seq_if;
    logic        START;
    logic        ABORT;
    logic [1:0]  MODE;
    logic [7:0]  NPULSES;
    logic [15:0] PERIOD;
    logic        WAIT_GTRG;
    logic        CAL_GTRG;
    logic        CCBINJ_REQ;
    logic        CCBPLS_REQ;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [7:0]  SENT;

    modport master (
        output START, ABORT, MODE, NPULSES, PERIOD, WAIT_GTRG, CAL_GTRG,
        input  CCBINJ_REQ, CCBPLS_REQ, BUSY, DONE, ERR, SENT
    );

    modport slave (
        input  START, ABORT, MODE, NPULSES, PERIOD, WAIT_GTRG, CAL_GTRG,
        output CCBINJ_REQ, CCBPLS_REQ, BUSY, DONE, ERR, SENT
    );
endinterface

// File: rtl/calib_burst_seq.sv
// Calibration burst sequencer: issues a programmed number of spaced inject/pulse
// requests to the calibration trigger path, optionally paced by CAL_GTRG.
module calib_burst_seq #(
    parameter int TMR    = 0,
    parameter int MINGAP = 128
) (
    input  logic             CLKCMS,
    input  logic             RST,
    calib_burst_seq_if.slave bus_if
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_TRG = 2'd2,
        S_GAP      = 2'd3
    } fsm_e;

    typedef struct packed {
        logic [1:0]  fsm;
        logic [1:0]  mode;
        logic [7:0]  npulses;
        logic [15:0] eff;
        logic        wait_g;
        logic        alt;
        logic [15:0] gap_cnt;
        logic [11:0] to_cnt;
        logic [7:0]  sent;
        logic        gtrg;
        logic        inj;
        logic        pls;
        logic        busy;
        logic        done;
        logic        err;
    } regs_t;

    localparam int          NCOPY    = (TMR != 0) ? 3 : 1;
    localparam logic [15:0] MINGAP_W = 16'(MINGAP);
    localparam logic [11:0] TO_LOAD  = 12'd4094;

    function automatic regs_t maj3(input regs_t a, input regs_t b, input regs_t c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    regs_t      st_s;
    regs_t      st_d;
    fsm_e       fsm_s;
    fsm_e       fsm_d;
    logic       trg_s;
    logic       timeout_s;
    logic       last_s;
    logic       start_s;
    logic [1:0] mode_v;
    logic       alt_v;
    logic [7:0] sent_v;
    logic       pls_v;

    for (genvar k = 0; k < NCOPY; k++) begin : g_copy
        regs_t copy_q;

        // State register copy holding FSM, counters, latched config and outputs.
        always_ff @(posedge CLKCMS or posedge RST) begin
            if (RST) begin
                copy_q <= '0;
            end else begin
                copy_q <= st_d;
            end
        end
    end

    if (NCOPY == 3) begin : g_vote
        assign st_s = maj3(g_copy[0].copy_q, g_copy[1].copy_q, g_copy[2].copy_q);
    end else begin : g_single
        assign st_s = g_copy[0].copy_q;
    end

    assign fsm_s     = fsm_e'(st_s.fsm);
    assign trg_s     = bus_if.CAL_GTRG & ~st_s.gtrg;
    assign timeout_s = (st_s.to_cnt == 12'd0) & ~trg_s;
    assign last_s    = (st_s.npulses != 8'd0) & (st_s.sent == st_s.npulses);
    assign start_s   = (fsm_s == S_IDLE) & bus_if.START & ~bus_if.ABORT;

    // Next-state logic; ABORT overrides every transition.
    always_comb begin
        fsm_d = S_IDLE;
        if (bus_if.ABORT) begin
            fsm_d = S_IDLE;
        end else begin
            case (fsm_s)
                S_IDLE: begin
                    fsm_d = bus_if.START ? S_ISSUE : S_IDLE;
                end
                S_ISSUE: begin
                    if (st_s.wait_g) begin
                        fsm_d = S_WAIT_TRG;
                    end else if (last_s) begin
                        fsm_d = S_IDLE;
                    end else begin
                        fsm_d = S_GAP;
                    end
                end
                S_WAIT_TRG: begin
                    if (trg_s || timeout_s) begin
                        fsm_d = last_s ? S_IDLE : S_GAP;
                    end else begin
                        fsm_d = S_WAIT_TRG;
                    end
                end
                S_GAP: begin
                    fsm_d = (st_s.gap_cnt == 16'd0) ? S_ISSUE : S_GAP;
                end
                default: begin
                    fsm_d = S_IDLE;
                end
            endcase
        end
    end

    // Output and datapath next values, computed from the next state so every output is a flop.
    always_comb begin
        st_d      = st_s;
        st_d.fsm  = fsm_d;
        st_d.gtrg = bus_if.CAL_GTRG;
        st_d.inj  = 1'b0;
        st_d.pls  = 1'b0;
        st_d.busy = (fsm_d != S_IDLE);
        st_d.done = (fsm_s != S_IDLE) & (fsm_d == S_IDLE) & ~bus_if.ABORT;
        mode_v    = st_s.mode;
        alt_v     = st_s.alt;
        sent_v    = st_s.sent;
        pls_v     = 1'b0;

        if (start_s) begin
            mode_v       = (bus_if.MODE == 2'd3) ? 2'd0 : bus_if.MODE;
            alt_v        = 1'b0;
            sent_v       = 8'd0;
            st_d.mode    = mode_v;
            st_d.npulses = bus_if.NPULSES;
            st_d.eff     = (bus_if.PERIOD < MINGAP_W) ? MINGAP_W : bus_if.PERIOD;
            st_d.wait_g  = bus_if.WAIT_GTRG;
            st_d.err     = 1'b0;
            st_d.sent    = 8'd0;
        end else begin
            st_d.mode = st_s.mode;
        end

        // alt_v = 1 means the previous request was an inject (only used in alternate mode).
        if (fsm_d == S_ISSUE) begin
            pls_v       = (mode_v == 2'd1) | ((mode_v == 2'd2) & alt_v);
            st_d.pls    = pls_v;
            st_d.inj    = ~pls_v;
            st_d.alt    = ~alt_v;
            st_d.sent   = sat_inc8(sent_v);
            st_d.to_cnt = TO_LOAD;
        end else begin
            st_d.alt = alt_v;
        end

        if ((fsm_d == S_GAP) && (fsm_s != S_GAP)) begin
            st_d.gap_cnt = st_s.eff - 16'd2;
        end else if ((fsm_s == S_GAP) && (st_s.gap_cnt != 16'd0)) begin
            st_d.gap_cnt = st_s.gap_cnt - 16'd1;
        end else begin
            st_d.gap_cnt = st_s.gap_cnt;
        end

        if ((fsm_s == S_WAIT_TRG) && !bus_if.ABORT) begin
            if (timeout_s) begin
                st_d.err = 1'b1;
            end else if (st_s.to_cnt != 12'd0) begin
                st_d.to_cnt = st_s.to_cnt - 12'd1;
            end else begin
                st_d.to_cnt = st_s.to_cnt;
            end
        end else begin
            st_d.gtrg = bus_if.CAL_GTRG;
        end
    end

    assign bus_if.CCBINJ_REQ = st_s.inj;
    assign bus_if.CCBPLS_REQ = st_s.pls;
    assign bus_if.BUSY       = st_s.busy;
    assign bus_if.DONE       = st_s.done;
    assign bus_if.ERR        = st_s.err;
    assign bus_if.SENT       = st_s.sent;

endmodule

// File: tb/tb_calib_burst_seq.sv
// Directed self-checking bench for calib_burst_seq (triplicated build).
module tb_calib_burst_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   s      = 0;
    logic busy_prev = 1'b0;
    logic err_prev  = 1'b0;
    int   inj_q[$];
    int   pls_q[$];
    int   done_q[$];
    int   bfall_q[$];
    int   err_q[$];

    calib_burst_seq_if bus();

    calib_burst_seq #(.TMR(1), .MINGAP(128)) dut (
        .CLKCMS (clk),
        .RST    (rst),
        .bus_if (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        else return -1;
    endfunction

    // Advance to the next falling edge and log output events by cycle number.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.CCBINJ_REQ) inj_q.push_back(cyc);
        if (bus.CCBPLS_REQ) pls_q.push_back(cyc);
        if (bus.DONE) done_q.push_back(cyc);
        if (busy_prev && !bus.BUSY) bfall_q.push_back(cyc);
        if (bus.ERR && !err_prev) err_q.push_back(cyc);
        busy_prev = bus.BUSY;
        err_prev  = bus.ERR;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_log();
        inj_q.delete();
        pls_q.delete();
        done_q.delete();
        bfall_q.delete();
        err_q.delete();
    endtask

    task automatic set_cfg(input logic [1:0] m, input logic [7:0] np,
                           input logic [15:0] per, input logic wg);
        bus.MODE      = m;
        bus.NPULSES   = np;
        bus.PERIOD    = per;
        bus.WAIT_GTRG = wg;
        bus.START     = 1'b1;
    endtask

    task automatic start_burst(input logic [1:0] m, input logic [7:0] np,
                               input logic [15:0] per, input logic wg, output int st);
        set_cfg(m, np, per, wg);
        st = cyc;
        tick();
        bus.START = 1'b0;
    endtask

    // Runs n cycles answering each request with a one-cycle CAL_GTRG dly cycles later (dly < 0: never).
    task automatic run_gtrg(input int n, input int dly);
        int due = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            bus.START = 1'b0;
            if (bus.CCBINJ_REQ || bus.CCBPLS_REQ) due = cyc + dly;
            bus.CAL_GTRG = (dly >= 0) && (cyc == due);
        end
        bus.CAL_GTRG = 1'b0;
    endtask

    task automatic check_scn1(input int st, input string p);
        check({p, "_inj_n"},  inj_q.size(), 3);
        check({p, "_inj0"},   at(inj_q, 0), st + 1);
        check({p, "_inj1"},   at(inj_q, 1), st + 201);
        check({p, "_inj2"},   at(inj_q, 2), st + 401);
        check({p, "_pls_n"},  pls_q.size(), 0);
        check({p, "_done_n"}, done_q.size(), 1);
        check({p, "_done"},   at(done_q, 0), st + 402);
        check({p, "_bfall"},  at(bfall_q, 0), st + 402);
        check({p, "_sent"},   int'(bus.SENT), 3);
        check({p, "_err"},    int'(bus.ERR), 0);
    endtask

    initial begin
        bus.START     = 1'b0;
        bus.ABORT     = 1'b0;
        bus.MODE      = 2'd0;
        bus.NPULSES   = 8'd0;
        bus.PERIOD    = 16'd0;
        bus.WAIT_GTRG = 1'b0;
        bus.CAL_GTRG  = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("reset_outs", int'({bus.CCBINJ_REQ, bus.CCBPLS_REQ, bus.BUSY, bus.DONE, bus.ERR}), 0);
        check("reset_sent", int'(bus.SENT), 0);
        run(2);
        rst = 1'b0;
        run(8);

        // Inject-only burst, no pacing.
        clear_log();
        start_burst(2'd0, 8'd3, 16'd200, 1'b0, s);
        check("s1_start_cyc", s, 10);
        run(420);
        check_scn1(s, "s1");

        // Alternate mode with the minimum spacing enforced; a START mid-burst must not relatch.
        clear_log();
        start_burst(2'd2, 8'd4, 16'd10, 1'b0, s);
        run(49);
        set_cfg(2'd1, 8'd1, 16'd300, 1'b1);
        tick();
        bus.START = 1'b0;
        run(350);
        check("s2_inj_n", inj_q.size(), 2);
        check("s2_pls_n", pls_q.size(), 2);
        check("s2_inj0",  at(inj_q, 0), s + 1);
        check("s2_pls0",  at(pls_q, 0), s + 129);
        check("s2_inj1",  at(inj_q, 1), s + 257);
        check("s2_pls1",  at(pls_q, 1), s + 385);
        check("s2_done",  at(done_q, 0), s + 386);
        check("s2_sent",  int'(bus.SENT), 4);

        // Paced by CAL_GTRG arriving 130 cycles after each request.
        clear_log();
        set_cfg(2'd0, 8'd2, 16'd128, 1'b1);
        s = cyc;
        run_gtrg(500, 130);
        check("s3_inj_n",   inj_q.size(), 2);
        check("s3_inj0",    at(inj_q, 0), s + 1);
        check("s3_inj1",    at(inj_q, 1), s + 259);
        check("s3_done_n",  done_q.size(), 1);
        check("s3_done",    at(done_q, 0), s + 390);
        check("s3_bfall",   at(bfall_q, 0), s + 390);
        check("s3_err",     int'(bus.ERR), 0);

        // CAL_GTRG never returns: both waits time out, burst still completes.
        clear_log();
        set_cfg(2'd0, 8'd2, 16'd128, 1'b1);
        s = cyc;
        run_gtrg(8400, -1);
        check("s4_err_rise", at(err_q, 0), s + 4097);
        check("s4_inj1",     at(inj_q, 1), s + 4224);
        check("s4_done",     at(done_q, 0), s + 8320);
        check("s4_err_kept", int'(bus.ERR), 1);

        // Free-running pulse burst stopped by ABORT; next START clears ERR.
        clear_log();
        start_burst(2'd1, 8'd0, 16'd128, 1'b0, s);
        check("s5_err_clr", int'(bus.ERR), 0);
        run(306);
        check("s5_busy_pre", int'(bus.BUSY), 1);
        bus.ABORT = 1'b1;
        tick();
        bus.ABORT = 1'b0;
        check("s5_busy_abort", int'(bus.BUSY), 0);
        run(300);
        check("s5_pls_n",  pls_q.size(), 3);
        check("s5_pls2",   at(pls_q, 2), s + 257);
        check("s5_inj_n",  inj_q.size(), 0);
        check("s5_done_n", done_q.size(), 0);
        check("s5_bfall",  at(bfall_q, 0), s + 308);
        check("s5_sent",   int'(bus.SENT), 3);

        clear_log();
        set_cfg(2'd0, 8'd5, 16'd128, 1'b0);
        bus.ABORT = 1'b1;
        tick();
        bus.START = 1'b0;
        bus.ABORT = 1'b0;
        run(200);
        check("s5b_req_n", inj_q.size() + pls_q.size(), 0);
        check("s5b_busy",  int'(bus.BUSY), 0);
        check("s5b_sent",  int'(bus.SENT), 3);

        // Asynchronous reset in GAP, then a fresh burst behaves like the first one.
        clear_log();
        start_burst(2'd0, 8'd3, 16'd200, 1'b0, s);
        run(59);
        #2 rst = 1'b1;
        #1;
        check("s6_rst_busy", int'(bus.BUSY), 0);
        check("s6_rst_sent", int'(bus.SENT), 0);
        tick();
        rst = 1'b0;
        run(5);
        check("s6_post_outs", int'({bus.CCBINJ_REQ, bus.CCBPLS_REQ, bus.BUSY, bus.DONE, bus.ERR}), 0);
        check("s6_post_sent", int'(bus.SENT), 0);
        clear_log();
        start_burst(2'd0, 8'd3, 16'd200, 1'b0, s);
        run(420);
        check_scn1(s, "s6");

        // Reset during a request pulse truncates it immediately.
        start_burst(2'd0, 8'd3, 16'd200, 1'b0, s);
        check("s7_inj_hi", int'(bus.CCBINJ_REQ), 1);
        #2 rst = 1'b1;
        #1;
        check("s7_inj_cut", int'(bus.CCBINJ_REQ), 0);
        tick();
        rst = 1'b0;
        run(3);
        check("s7_busy", int'(bus.BUSY), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/calib_burst_seq.md
# calib_burst_seq

Calibration burst sequencer on CLKCMS that drives the CCB-style inject/pulse request inputs of the calibration trigger block. It issues a programmed number of single-cycle inject or pulse requests at a guaranteed minimum spacing. Optionally it waits for each returned CAL_GTRG before scheduling the next request. It sits between the JTAG configuration registers and the calibration trigger path, so software can run calibration runs without per-pulse CCB commands.

## Interface
Parameters:
- TMR, 0, 1 = triplicate FSM state and counters with majority vote; function identical to TMR=0
- MINGAP, 128, minimum request-to-request spacing in CLKCMS cycles; covers the 64-count pulse-hold window of the trigger path

Ports:
- CLKCMS  in  1  system clock; all logic is rising-edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  single-cycle burst start; ignored while BUSY=1
- ABORT  in  1  terminate burst; highest priority
- MODE  in  2  0 = inject only, 1 = pulse only, 2 = alternate (inject first), 3 = treated as 0
- NPULSES  in  8  requests per burst; 0 = free-run until ABORT
- PERIOD  in  16  spacing in cycles; effective spacing EFF = max(PERIOD, MINGAP)
- WAIT_GTRG  in  1  1 = wait for the CAL_GTRG rising edge after each request
- CAL_GTRG  in  1  returned calibration L1A from the trigger path
- CCBINJ_REQ  out  1  one-cycle inject request
- CCBPLS_REQ  out  1  one-cycle pulse request
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse on normal burst completion
- ERR  out  1  sticky CAL_GTRG timeout flag
- SENT  out  8  requests issued in the current or last burst; saturates at 255

## Operation
- FSM states are IDLE, ISSUE, WAIT_TRG, GAP.
- IDLE -> ISSUE on START=1 and ABORT=0. On that edge the block latches MODE, NPULSES, PERIOD and WAIT_GTRG, and clears SENT and ERR. Input changes during a burst have no effect.
- ISSUE, one cycle:
  - Drives exactly one of CCBINJ_REQ or CCBPLS_REQ for that cycle. The choice follows the latched MODE; in MODE 2 it toggles per request.
  - SENT increments.
  - Next state is WAIT_TRG if WAIT_GTRG=1, otherwise GAP. On the last request with WAIT_GTRG=0, next state is IDLE and DONE pulses.
- WAIT_TRG:
  - A CAL_GTRG rising edge (CAL_GTRG=1 while the registered copy = 0) leads to GAP, or to IDLE with DONE if that was the last request.
  - Timeout is 4096 cycles after ISSUE. On timeout ERR is set and the FSM proceeds as if the edge had arrived.
  - CAL_GTRG edges in any other state are ignored.
- GAP: counts down, then goes to ISSUE so the interval rule in Timing holds.
- Last request: SENT == latched NPULSES with NPULSES != 0. With NPULSES = 0 the burst never completes on its own and SENT saturates at 255.
- ABORT=1 in any state forces IDLE on the next edge. ABORT produces no DONE, and no request in that cycle or later. ERR and SENT are kept.
- START in the same cycle as ABORT: ABORT wins.
- START while BUSY: ignored, with no relatch.

## Timing
- Reset values: state IDLE, CCBINJ_REQ = 0, CCBPLS_REQ = 0, BUSY = 0, DONE = 0, ERR = 0, SENT = 0. The CAL_GTRG edge register resets to 0.
- All outputs are registered.
- START sampled at edge n gives the first request high in cycle n+1; BUSY rises at n+1.
- WAIT_GTRG=0: consecutive request pulses are exactly EFF cycles apart, rising edge to rising edge.
- WAIT_GTRG=1: the next request comes exactly EFF cycles after the cycle in which the CAL_GTRG edge (or the timeout) is detected.
- DONE and BUSY fall together:
  - WAIT_GTRG=0: DONE is high the cycle after the last request; BUSY is low in that same cycle.
  - WAIT_GTRG=1: DONE is high the cycle after the final edge or timeout is detected.
- RST mid-burst clears everything immediately, asynchronously, and any in-progress request pulse is truncated.

## Test plan
- MODE=0, NPULSES=3, PERIOD=200, WAIT_GTRG=0, START at cycle 10 -> CCBINJ_REQ high at cycles 11, 211 and 411; DONE at 412; SENT=3; CCBPLS_REQ never high.
- MODE=2, NPULSES=4, PERIOD=10 -> the 128-cycle minimum is enforced; requests go INJ, PLS, INJ, PLS at cycles 11, 139, 267, 395.
- WAIT_GTRG=1, NPULSES=2, PERIOD=128, CAL_GTRG pulsed 130 cycles after each request -> second request 258 cycles after the first; DONE one cycle after the second CAL_GTRG edge; ERR=0.
- WAIT_GTRG=1, CAL_GTRG held low -> ERR=1 at 4096 cycles after the first request; the burst continues and completes with DONE; ERR stays set until the next START.
- NPULSES=0, ABORT 50 cycles after the third request -> BUSY low the next cycle; no DONE and no further requests; SENT=3. START in the same cycle as ABORT from IDLE -> no request.
- RST asserted during GAP, then released -> all outputs 0. A new START behaves exactly like the first scenario.
